// File: rtl/whack_game_fsm.sv
// whack_game_fsm: single-target reaction game with game timer, per-level hit window,
// switch-toggle detection and scoring. Define STREAK_BONUS_EN for 2-point streak hits.
module whack_game_fsm #(
   parameter int LED_NUM        = 18,
   parameter int SCORE_W        = 7,
   parameter int GAME_SECONDS   = 60,
   parameter int BASE_WINDOW_MS = 1500,
   parameter int WINDOW_STEP_MS = 100,
   parameter int MIN_WINDOW_MS  = 300,
   parameter int HITS_PER_LEVEL = 5,
   parameter int MAX_LEVEL      = 15
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              ms_tick,
   input  logic                              button_edge,
   input  logic [LED_NUM-1:0]                switches,
   input  logic [$clog2(LED_NUM)-1:0]        random_value,
   output logic [LED_NUM-1:0]                led_on,
   output logic [SCORE_W-1:0]                user_score,
   output logic [3:0]                        level,
   output logic [$clog2(GAME_SECONDS+1)-1:0] game_time_left,
   output logic                              game_active,
   output logic                              game_over,
   output logic                              hit_pulse,
   output logic                              miss_pulse
);
   localparam int IW = $clog2(LED_NUM);
   localparam int TW = $clog2(GAME_SECONDS + 1);
   localparam int HW = $clog2(HITS_PER_LEVEL + 1);
   localparam logic [LED_NUM-1:0] ONE_HOT0 = {{(LED_NUM-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, PICK, SHOW, GAME_OVER} state_t;

   state_t             state_q;
   logic [LED_NUM-1:0] sw_prev_q, led_q;
   logic [IW-1:0]      tgt_q;
   logic [15:0]        win_cnt_q;
   logic [9:0]         ms_sub_q;
   logic [SCORE_W-1:0] score_q;
   logic [3:0]         level_q;
   logic [TW-1:0]      time_q;
   logic [HW-1:0]      hits_q;
   logic               active_q, over_q, hit_q, miss_q;

   logic [LED_NUM-1:0] tog_d, tgt_mask_d, pick_mask_d;
   logic [IW-1:0]      tgt_red_d, tgt_d;
   logic [15:0]        step_d, win_d;
   logic               hit_d, wrong_d, timeout_d, sec_wrap_d, last_sec_d;
   logic [1:0]         add_d;
   logic [SCORE_W:0]   score_sum_d;
   logic [SCORE_W-1:0] score_hit_d, score_miss_d;

`ifdef STREAK_BONUS_EN
   logic [1:0] streak_q, streak_d;
`endif

   always_comb begin
      tog_d       = switches ^ sw_prev_q;
      tgt_mask_d  = ONE_HOT0 << tgt_q;
      hit_d       = tog_d[tgt_q];
      wrong_d     = |(tog_d & ~tgt_mask_d);
      timeout_d   = ms_tick && (win_cnt_q == 16'd1);
      sec_wrap_d  = ms_tick && (ms_sub_q == 10'd999);
      last_sec_d  = sec_wrap_d && (time_q == TW'(1));
      tgt_red_d   = random_value;
      if (int'(random_value) >= LED_NUM)
         tgt_red_d = IW'(int'(random_value) - LED_NUM);
      tgt_d = tgt_red_d;
      // Never show the same LED twice in a row.
      if (tgt_red_d == tgt_q)
         tgt_d = (int'(tgt_red_d) == LED_NUM - 1) ? '0 : tgt_red_d + IW'(1);
      pick_mask_d = ONE_HOT0 << tgt_d;
      step_d      = (16'(level_q) - 16'd1) * 16'(WINDOW_STEP_MS);
      if (step_d >= 16'(BASE_WINDOW_MS - MIN_WINDOW_MS))
         win_d = 16'(MIN_WINDOW_MS);
      else
         win_d = 16'(BASE_WINDOW_MS) - step_d;
      add_d = 2'd1;
`ifdef STREAK_BONUS_EN
      if (streak_q == 2'd3)
         add_d = 2'd2;
`endif
      score_sum_d  = {1'b0, score_q} + (SCORE_W+1)'(add_d);
      score_hit_d  = score_sum_d[SCORE_W] ? '1 : score_sum_d[SCORE_W-1:0];
      score_miss_d = (score_q == '0) ? '0 : score_q - SCORE_W'(1);
   end

`ifdef STREAK_BONUS_EN
   // Saturates at 3: only "3 or more" matters for the bonus.
   always_comb begin
      streak_d = streak_q;
      if (state_q == IDLE && button_edge)
         streak_d = '0;
      else if (state_q == SHOW) begin
         if (hit_d)
            streak_d = (streak_q == 2'd3) ? streak_q : streak_q + 2'd1;
         else if (wrong_d || timeout_d)
            streak_d = '0;
      end
   end

   always_ff @(posedge clk)
      streak_q <= !reset_n ? 2'd0 : streak_d;
`endif

   always_ff @(posedge clk) begin
      sw_prev_q <= switches;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      if (!reset_n) begin
         state_q   <= IDLE;
         led_q     <= '0;
         tgt_q     <= '0;
         win_cnt_q <= '0;
         ms_sub_q  <= '0;
         score_q   <= '0;
         level_q   <= '0;
         time_q    <= '0;
         hits_q    <= '0;
         active_q  <= 1'b0;
         over_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (button_edge) begin
               score_q  <= '0;
               level_q  <= 4'd1;
               hits_q   <= '0;
               time_q   <= TW'(GAME_SECONDS);
               ms_sub_q <= '0;
               active_q <= 1'b1;
               state_q  <= PICK;
            end
            PICK, SHOW: begin
               if (ms_tick)
                  ms_sub_q <= sec_wrap_d ? 10'd0 : ms_sub_q + 10'd1;
               if (sec_wrap_d)
                  time_q <= time_q - TW'(1);
               if (state_q == PICK) begin
                  tgt_q     <= tgt_d;
                  win_cnt_q <= win_d;
                  led_q     <= pick_mask_d;
                  state_q   <= SHOW;
               end else begin
                  if (ms_tick)
                     win_cnt_q <= win_cnt_q - 16'd1;
                  if (hit_d) begin
                     score_q <= score_hit_d;
                     hit_q   <= 1'b1;
                     led_q   <= '0;
                     state_q <= PICK;
                     if (hits_q == HW'(HITS_PER_LEVEL - 1)) begin
                        hits_q <= '0;
                        if (level_q < 4'(MAX_LEVEL))
                           level_q <= level_q + 4'd1;
                     end else begin
                        hits_q <= hits_q + HW'(1);
                     end
                  end else if (wrong_d || timeout_d) begin
                     if (wrong_d)
                        score_q <= score_miss_d;
                     miss_q  <= 1'b1;
                     led_q   <= '0;
                     state_q <= PICK;
                  end
               end
               // Final second expires: the same-cycle event above is still scored.
               if (last_sec_d) begin
                  led_q    <= '1;
                  active_q <= 1'b0;
                  over_q   <= 1'b1;
                  state_q  <= GAME_OVER;
               end
            end
            GAME_OVER: if (button_edge) begin
               led_q   <= '0;
               level_q <= '0;
               over_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign led_on         = led_q;
   assign user_score     = score_q;
   assign level          = level_q;
   assign game_time_left = time_q;
   assign game_active    = active_q;
   assign game_over      = over_q;
   assign hit_pulse      = hit_q;
   assign miss_pulse     = miss_q;
endmodule

// File: doc/whack_game_fsm.md
Name: whack_game_fsm

Overview:
Parametrised successor to the single-target reaction game controller. Owns the game timer, per-level hit window, switch-edge detection, scoring with penalty, and level progression internally. Needs only a 1 kHz strobe, a button edge and a random index. Sits between the debounced board inputs (KEY/SW) and the LED and 7-segment display drivers.

Parameters:
LED_NUM, 18, number of target LEDs/switches
SCORE_W, 7, score width; score saturates at 2^SCORE_W-1
GAME_SECONDS, 60, game length in seconds
BASE_WINDOW_MS, 1500, hit window at level 1
WINDOW_STEP_MS, 100, window reduction per level
MIN_WINDOW_MS, 300, window floor
HITS_PER_LEVEL, 5, hits needed to advance one level
MAX_LEVEL, 15, level ceiling (level port is 4 bits)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
ms_tick  in  1  one-cycle strobe every 1 ms
button_edge  in  1  one-cycle start/acknowledge pulse
switches  in  LED_NUM  raw switch levels (already synchronised)
random_value  in  $clog2(LED_NUM)  free-running random index
led_on  out  LED_NUM  one-hot target; all-ones in GAME_OVER
user_score  out  SCORE_W  current score
level  out  4  current level: 0 idle, 1..MAX_LEVEL in play
game_time_left  out  $clog2(GAME_SECONDS+1)  seconds remaining
game_active  out  1  high in PICK/SHOW
game_over  out  1  high in GAME_OVER
hit_pulse  out  1  one-cycle pulse on hit
miss_pulse  out  1  one-cycle pulse on wrong switch or timeout

Behaviour:
- Clock and reset: clk is the only clock. reset_n is sampled synchronously and is active-low. Reset takes priority over everything, including mid-game.
- Reset state: state=IDLE; led_on=0, user_score=0, level=0, game_time_left=0, all flags and pulses 0. The switch history register is loaded with the current switches, so there is no false toggle after reset.
- Toggle detection: tog = switches ^ sw_prev, with sw_prev registered every cycle. A toggle in either direction counts as a press.
- IDLE: LEDs off. On button_edge, the next cycle sets score=0, level=1, streak=0, hits_in_level=0, game_time_left=GAME_SECONDS, ms_sub=0, then goes to PICK.
- PICK (1 cycle):
  - tgt = random_value, reduced by LED_NUM if random_value >= LED_NUM.
  - If tgt equals the previous target, use (tgt+1) mod LED_NUM.
  - Load win_cnt = max(MIN_WINDOW_MS, BASE_WINDOW_MS - (level-1)*WINDOW_STEP_MS).
  - Go to SHOW.
- SHOW: led_on = 1<<tgt. Each cycle, priority is hit > wrong > timeout:
  - hit: tog[tgt]=1. Score +1 (saturating), hit_pulse, streak+1, hits_in_level+1. When hits_in_level reaches HITS_PER_LEVEL, it clears and level increments if level < MAX_LEVEL. Go to PICK.
  - wrong: any tog bit other than tgt is set. Score -1, floored at 0. miss_pulse, streak=0. Go to PICK.
  - timeout: ms_tick with win_cnt==1 (win_cnt decrements on ms_tick). miss_pulse, no score change, streak=0. Go to PICK.
- Game clock: runs in PICK/SHOW. ms_sub counts ms_tick 0..999; at wrap, game_time_left decrements.
  - When game_time_left would reach 0, go to GAME_OVER.
  - A hit or wrong event in that same cycle is still scored and pulsed before entering GAME_OVER.
- GAME_OVER: led_on all ones; game_over=1; score and level are held. button_edge goes to IDLE. Score persists in IDLE until the next start.
- button_edge is ignored in PICK/SHOW.
- Toggles in PICK, IDLE or GAME_OVER are ignored; sw_prev is still updated.
- Arithmetic: window math is done at 16 bits, then clamped. The level ceiling is enforced before the window is computed.

Optional Feature:
- Macro: STREAK_BONUS_EN.
- Defined: a hit made while streak >= 3 (i.e. the 4th and later consecutive hits) adds 2 instead of 1, still saturating. Level progression counts hits, not points.
- Undefined: every hit adds 1, and the streak counter is not synthesised.

Test Plan:
1. Reset mid-game (reset_n=0 for 1 cycle during SHOW, level 3, score 12) -> next cycle state IDLE, led_on=0, score=0, level=0, no pulses.
2. random_value=5, button_edge, then toggle SW5 -> led_on=0x00020 in SHOW, then hit_pulse, score=1. With random_value held at 5, the next target is 6 (led_on=0x00040).
3. Toggle SW2 while target is 6, score=0 -> miss_pulse, score stays 0. Then hit twice and toggle SW0 -> score 2 then 1.
4. No input at level 1 -> miss_pulse exactly 1500 ms_ticks after SHOW entry. After 5 hits, level=2 and the next window is 1400 ticks. Level never exceeds 15; window never drops below 300.
5. GAME_SECONDS=2 override, with a hit toggle on the final tick cycle -> score increments, game_over=1, led_on=all ones, game_time_left=0. button_edge -> IDLE.
6. STREAK_BONUS_EN, 5 consecutive hits -> score 1,2,3,5,7. Then a miss -> next hit adds 1. With SCORE_W=7 at 126 and the bonus active, score saturates at 127.
